ram2_ctrl: RTL
==============

Name: ram2_ctrl

Overview:
- CPU-side initiator for the single-ported external RAM2 SRAM. It holds both instruction fetch (IF stage, by pc) and data access (MEM stage, load/store) for the same 16-bit word-addressed memory.
- Serialises the two requesters on one physical bus, MEM before IF.
- Drives SRAM strobes with safe write timing.
- Raises stall_req to freeze the pipeline while a data access occupies the bus.

Parameters:
- RAM_ADDR_W, 18, width of physical SRAM address; the upper bits are zero-filled from 16-bit CPU addresses.
- NOP_INST, 16'h0800, value presented on inst after reset.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous reset, active-low
- pc  in  16  fetch word address
- inst  out  16  registered fetched instruction
- mem_addr_i  in  16  data word address
- mem_data_i  in  16  store data
- mem_data_o  out  16  registered load data
- mem_re  in  1  load request
- mem_we  in  1  store request
- mem_ce  in  1  data access enable; qualifies mem_re and mem_we
- stall_req  out  1  pipeline stall request
- ram2_addr  out  RAM_ADDR_W  SRAM address
- ram2_data  inout  16  SRAM data bus
- ram2_en_n  out  1  SRAM chip enable, active-low
- ram2_oe_n  out  1  SRAM output enable, active-low
- ram2_we_n  out  1  SRAM write enable, active-low

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - state=FETCH, mem_done=0, inst=NOP_INST, mem_data_o=0.
  - ram2_en_n=1, ram2_oe_n=1, ram2_we_n=1, ram2_data=Z, ram2_addr=0.
  - A store interrupted by reset must never leave we_n low.
- Request decode: ld = mem_ce&mem_re&~mem_we; st = mem_ce&mem_we. If mem_re and mem_we are both set, the store wins.
- Address mapping: ram2_addr = {zeros, 16-bit address}. ram2_en_n=0 in every non-reset cycle.
- ram2_data is driven only in write states; otherwise it is Z.
- FSM states: FETCH, WR_PULSE, WR_HOLD.
- FETCH, no pending data access (no ld/st, or mem_done=1):
  - addr=pc, oe_n=0, stall_req=0.
  - Posedge: inst<=ram2_data, mem_done<=0. Fetch latency is 1 cycle.
- FETCH with ld and mem_done=0:
  - addr=mem_addr_i, oe_n=0, stall_req=1.
  - Posedge: mem_data_o<=ram2_data, mem_done<=1. inst holds.
  - A load therefore costs 2 cycles: one data cycle, then one fetch cycle.
- FETCH with st and mem_done=0 (setup cycle):
  - addr=mem_addr_i, data=mem_data_i driven, oe_n=1, we_n=1, stall_req=1.
  - Next state: WR_PULSE.
- WR_PULSE: addr and data held, we_n=0, oe_n=1, stall_req=1. Next state: WR_HOLD.
- WR_HOLD: we_n=1, addr and data still driven, stall_req=1. Posedge: mem_done<=1, next state FETCH.
- A store costs 4 cycles. A fetch that follows a store to the same address (pc == store address) returns the new data.
- Inputs are assumed stable while stall_req=1. Address and data are re-sampled combinationally each cycle, with no input registers.
- oe_n and we_n are never low in the same cycle.
- The data bus is released (Z) in the same cycle oe_n goes low.

Optional Feature:
- Macro: RAM2_RD_WAIT_EN.
- Defined: every SRAM read (fetch or load) takes 2 cycles.
  - Cycle 1 presents the address with oe_n=0 and does not capture; internal rd_wait flag set.
  - Cycle 2 captures the data.
  - stall_req=1 during cycle 1 of a fetch; fetch throughput is 1 instruction per 2 cycles; a load costs 4 cycles.
- Undefined: single-cycle reads as above.
- Writes are unaffected in both cases.

Decomposition:
- defines.v holds:
  - state encodings RAM2_ST_FETCH/RAM2_ST_WR_PULSE/RAM2_ST_WR_HOLD (2 bits);
  - NOP_INST value;
  - ZeroWord (16'h0000);
  - high-impedance constant HighZ16.
- One natural sub-module: ram2_tristate, a 16-bit bus driver. Inputs: drive enable and out value. Outputs: the sampled in value and the inout pin.

Test Plan:
- Reset: assert rst=0 mid-WR_PULSE → we_n=1 and ram2_data=Z in the same cycle; inst=16'h0800, stall_req=0.
- Fetch stream: SRAM preloaded with [0]=1111, [1]=2222, [2]=3333; pc=0,1,2 on consecutive cycles → inst=1111, 2222, 3333 one cycle after each; stall_req stays 0.
- Load: pc=5 ([5]=ABCD), ld from 0x0040 ([0x40]=1234) → stall_req=1 for 1 cycle, mem_data_o=1234, then inst=ABCD; ram2_addr sequence 0x00040, 0x00005.
- Store: st 0x0010←BEEF with pc=3 → stall 3 cycles; we_n low exactly 1 cycle, with addr=0x00010 and data=BEEF stable one cycle before and after; then SRAM[0x10]=BEEF and inst=SRAM[3].
- Conflict: mem_re=mem_we=1, mem_ce=1 → treated as a store (we_n pulse), mem_data_o unchanged. With mem_ce=0 and re=we=1 → plain fetch, no stall.
- With RAM2_RD_WAIT_EN: pc steps 0→1 → stall_req alternates 1,0; each inst update comes 2 cycles after the address is presented.

Source files
------------

// File: rtl/ram2_ctrl_pkg.sv
// Shared types and constants for the RAM2 SRAM controller.
package ram2_ctrl_pkg;

  typedef enum logic [1:0] {
    RAM2_ST_FETCH    = 2'd0,
    RAM2_ST_WR_PULSE = 2'd1,
    RAM2_ST_WR_HOLD  = 2'd2
  } ram2_st_e;

  localparam logic [15:0] NOP_INST_DEF = 16'h0800;
  localparam logic [15:0] ZERO_WORD    = 16'h0000;
  localparam logic [15:0] HIGH_Z16     = 16'hzzzz;

  // A request with both re and we set is a store.
  function automatic logic is_load(input logic ce, input logic re, input logic we);
    return ce & re & ~we;
  endfunction

  function automatic logic is_store(input logic ce, input logic we);
    return ce & we;
  endfunction

endpackage

// File: rtl/ram2_ctrl_if.sv
// CPU-side fetch/data port of the RAM2 controller.
interface ram2_ctrl_if;
  logic [15:0] pc;
  logic [15:0] inst;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_data_i;
  logic [15:0] mem_data_o;
  logic        mem_re;
  logic        mem_we;
  logic        mem_ce;
  logic        stall_req;

  modport master (
    output pc, mem_addr_i, mem_data_i, mem_re, mem_we, mem_ce,
    input  inst, mem_data_o, stall_req
  );

  modport slave (
    input  pc, mem_addr_i, mem_data_i, mem_re, mem_we, mem_ce,
    output inst, mem_data_o, stall_req
  );
endinterface

// File: rtl/ram2_tristate.sv
// 16-bit bidirectional pad driver for the RAM2 data bus.
module ram2_tristate
  import ram2_ctrl_pkg::*;
(
  input  logic        drive_en,
  input  logic [15:0] out_val,
  output logic [15:0] in_val,
  inout  wire  [15:0] pin
);

  assign pin    = drive_en ? out_val : HIGH_Z16;
  assign in_val = pin;

endmodule

// File: rtl/ram2_ctrl.sv
// RAM2 SRAM initiator: serialises MEM-stage loads/stores ahead of IF fetches.
// Define RAM2_RD_WAIT_EN for two-cycle SRAM reads (fetch and load).
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int          RAM_ADDR_W = 18,
  parameter logic [15:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ram2_ctrl_if.slave            cpu,
  output logic [RAM_ADDR_W-1:0] ram2_addr,
  inout  wire  [15:0]           ram2_data,
  output logic                  ram2_en_n,
  output logic                  ram2_oe_n,
  output logic                  ram2_we_n
);

  ram2_st_e    state, state_nxt;
  logic        mem_done;
  logic        ld, st;
  logic [15:0] addr_c, bus_in;
  logic        oe_n_c, we_n_c, drive_c, stall_c;
  logic        cap_inst, cap_data, done_set, done_clr;
  logic [15:0] inst_q, mdata_q;
`ifdef RAM2_RD_WAIT_EN
  logic        rd_wait, rd_wait_nxt;
`endif

  assign ld = is_load(cpu.mem_ce, cpu.mem_re, cpu.mem_we);
  assign st = is_store(cpu.mem_ce, cpu.mem_we);

  always_comb begin
    state_nxt = state;
    addr_c    = cpu.pc;
    oe_n_c    = 1'b1;
    we_n_c    = 1'b1;
    drive_c   = 1'b0;
    stall_c   = 1'b0;
    cap_inst  = 1'b0;
    cap_data  = 1'b0;
    done_set  = 1'b0;
    done_clr  = 1'b0;
`ifdef RAM2_RD_WAIT_EN
    rd_wait_nxt = 1'b0;
`endif
    unique case (state)
      RAM2_ST_FETCH: begin
        if (st && !mem_done) begin
          // Setup cycle: address and data settle before we_n falls.
          addr_c    = cpu.mem_addr_i;
          drive_c   = 1'b1;
          stall_c   = 1'b1;
          state_nxt = RAM2_ST_WR_PULSE;
        end else begin
          oe_n_c = 1'b0;
          if (ld && !mem_done) begin
            addr_c   = cpu.mem_addr_i;
            stall_c  = 1'b1;
            cap_data = 1'b1;
            done_set = 1'b1;
          end else begin
            cap_inst = 1'b1;
            done_clr = 1'b1;
          end
`ifdef RAM2_RD_WAIT_EN
          // First read cycle only presents the address; capture happens next.
          if (!rd_wait) begin
            stall_c     = 1'b1;
            cap_inst    = 1'b0;
            cap_data    = 1'b0;
            done_set    = 1'b0;
            done_clr    = 1'b0;
            rd_wait_nxt = 1'b1;
          end
`endif
        end
      end
      RAM2_ST_WR_PULSE: begin
        addr_c    = cpu.mem_addr_i;
        drive_c   = 1'b1;
        we_n_c    = 1'b0;
        stall_c   = 1'b1;
        state_nxt = RAM2_ST_WR_HOLD;
      end
      RAM2_ST_WR_HOLD: begin
        addr_c    = cpu.mem_addr_i;
        drive_c   = 1'b1;
        stall_c   = 1'b1;
        done_set  = 1'b1;
        state_nxt = RAM2_ST_FETCH;
      end
      default: state_nxt = RAM2_ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RAM2_ST_FETCH;
      mem_done <= 1'b0;
      inst_q   <= NOP_INST;
      mdata_q  <= ZERO_WORD;
    end else begin
      state <= state_nxt;
      if (done_set)      mem_done <= 1'b1;
      else if (done_clr) mem_done <= 1'b0;
      if (cap_inst) inst_q  <= bus_in;
      if (cap_data) mdata_q <= bus_in;
    end
  end

`ifdef RAM2_RD_WAIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_wait <= 1'b0;
    else      rd_wait <= rd_wait_nxt;
  end
`endif

  // Strobes are gated by reset directly so an interrupted write never holds we_n low.
  assign ram2_en_n     = ~rst;
  assign ram2_oe_n     = oe_n_c | ~rst;
  assign ram2_we_n     = we_n_c | ~rst;
  assign ram2_addr     = rst ? RAM_ADDR_W'(addr_c) : '0;
  assign cpu.stall_req = stall_c & rst;
  assign cpu.inst      = inst_q;
  assign cpu.mem_data_o = mdata_q;

  ram2_tristate u_bus (
    .drive_en (drive_c & rst),
    .out_val  (cpu.mem_data_i),
    .in_val   (bus_in),
    .pin      (ram2_data)
  );

endmodule
